// File: rtl/colortable_pkg.sv
// colortable_pkg -- shared definitions for the colour-table RAM slice.
//   clr_state_e : clear-sequencer FSM states (IDLE, CLEAR)
//   byte_lanes  : number of 8-bit lanes in a word of a given width
package colortable_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int unsigned byte_lanes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/colortable_clear_seq.sv
// colortable_clear_seq -- walks every table address once, ascending from 0,
// and owns the RAM write port while doing so.
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset; forces CLEAR at address 0
//   clear_req_i : one-cycle pulse requesting a full-table clear (ignored while busy)
//   busy_o      : high while the sequencer writes the table
//   clr_addr_o  : address written on the current edge while busy_o is high
module colortable_clear_seq
  import colortable_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_req_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  clr_state_e        state_q;
  logic              busy_q;
  // One spare MSB: it sets exactly when the last address has been written,
  // so the terminal test never aliases with address 0.
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  always_comb begin
    cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_req_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_d[ADDR_W]) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_addr_o = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/colortable_ram_be.sv
// colortable_ram_be -- byte-enabled colour-table RAM with a self-clearing
// sequencer. Storage is cleared to CLEAR_VAL after every reset and on request.
// Optional feature macro: COLORTABLE_BYPASS_EN -- when defined, a read that
// collides with an accepted write on the same edge returns the new bytes;
// otherwise the pre-write word is returned.
// Ports:
//   clock      : sole clock, rising edge
//   reset      : asynchronous active-high reset
//   clear_req  : one-cycle pulse requesting a full-table clear
//   busy       : high while the clear sequencer owns the write port
//   wren       : write request (ignored while busy)
//   wraddress  : write address
//   byteena_a  : per-byte write enable, bit i covers data[8i+7:8i]
//   data       : write data
//   enable     : read enable; q updates only when high
//   rdaddress  : read address
//   q          : registered read data
module colortable_ram_be
  import colortable_pkg::*;
#(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          ADDR_W    = 8,
  parameter logic [DATA_W-1:0]    CLEAR_VAL = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  wren,
  input  logic [ADDR_W-1:0]     wraddress,
  input  logic [DATA_W/8-1:0]   byteena_a,
  input  logic [DATA_W-1:0]     data,
  input  logic                  enable,
  input  logic [ADDR_W-1:0]     rdaddress,
  output logic [DATA_W-1:0]     q
);

  localparam int unsigned NB = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] q_q;

  colortable_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk_i       (clock),
    .rst_i       (reset),
    .clear_req_i (clear_req),
    .busy_o      (busy),
    .clr_addr_o  (clr_addr)
  );

  // Storage is deliberately not reset; the sequencer clears it after reset.
  always_ff @(posedge clock) begin
    if (busy) begin
      mem_q[clr_addr] <= CLEAR_VAL;
    end else if (wren) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (byteena_a[i]) begin
          mem_q[wraddress][8*i +: 8] <= data[8*i +: 8];
        end
      end
    end
  end

`ifdef COLORTABLE_BYPASS_EN
  logic wr_accept;
  assign wr_accept = wren & ~busy;

  always_comb begin
    rd_d = mem_q[rdaddress];
    if (wr_accept && (rdaddress == wraddress)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (byteena_a[i]) begin
          rd_d[8*i +: 8] = data[8*i +: 8];
        end
      end
    end
  end
`else
  always_comb begin
    rd_d = mem_q[rdaddress];
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (enable) begin
      q_q <= busy ? '0 : rd_d;
    end
  end

  assign q = q_q;

endmodule
